// File: rtl/aes128_pkg.sv
// Shared constants, state encoding and GF(2^8) helpers for the AES-128 decrypt core.
package aes128_pkg;

  localparam int unsigned NR      = 10;
  localparam int unsigned NK      = 4;
  localparam int unsigned BLOCK_W = NK * 32;

  typedef enum logic [1:0] {StIdle, StKeyx, StRound, StDone} state_e;

  // Forward key-expansion round constants, RCON[0] used for round key 1
  localparam logic [0:NR-1][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Row r of the column-major state rotates right by r byte positions
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    return {s[127:120], s[23:16],  s[47:40],  s[71:64],
            s[95:88],   s[119:112], s[15:8],  s[39:32],
            s[63:56],   s[87:80],  s[111:104], s[7:0],
            s[31:24],   s[55:48],  s[79:72],  s[103:96]};
  endfunction

endpackage

// File: rtl/aes128_dec_core_inv_mix_column.sv
// InvMixColumns for one 32-bit column, byte 0 at [31:24].
module InvMixColumn
  import aes128_pkg::*;
(
  input  logic [31:0] i_Col,
  output logic [31:0] o_Col
);

  logic [7:0] w_A0, w_A1, w_A2, w_A3;

  // Multiply the column by the fixed {0e,0b,0d,09} circulant
  always_comb begin
    {w_A0, w_A1, w_A2, w_A3} = i_Col;
    o_Col[31:24] = mul0e(w_A0) ^ mul0b(w_A1) ^ mul0d(w_A2) ^ mul09(w_A3);
    o_Col[23:16] = mul09(w_A0) ^ mul0e(w_A1) ^ mul0b(w_A2) ^ mul0d(w_A3);
    o_Col[15:8]  = mul0d(w_A0) ^ mul09(w_A1) ^ mul0e(w_A2) ^ mul0b(w_A3);
    o_Col[7:0]   = mul0b(w_A0) ^ mul0d(w_A1) ^ mul09(w_A2) ^ mul0e(w_A3);
  end

endmodule

// File: rtl/aes128_sbox.sv
// AES S-box, forward or inverse, computed from the field inverse and affine map.
module SBox
  import aes128_pkg::*;
(
  input  logic       i_fDec,
  input  logic [7:0] i_Byte,
  output logic [7:0] o_Byte
);

  logic [7:0] w_InvAff;
  logic [7:0] w_Inv;
  logic [7:0] w_FwdAff;

  // Inverse direction undoes the affine map first; forward applies it after inversion
  always_comb begin
    w_InvAff = rotl8(i_Byte, 1) ^ rotl8(i_Byte, 3) ^ rotl8(i_Byte, 6) ^ 8'h05;
    w_Inv    = gf_inv(i_fDec ? w_InvAff : i_Byte);
    w_FwdAff = w_Inv ^ rotl8(w_Inv, 1) ^ rotl8(w_Inv, 2) ^ rotl8(w_Inv, 3) ^
               rotl8(w_Inv, 4) ^ 8'h63;
    o_Byte   = i_fDec ? w_Inv : w_FwdAff;
  end

endmodule

// File: rtl/aes128_sub_byte.sv
// Byte substitution across a full 128-bit state.
module SubByte (
  input  logic         i_fDec,
  input  logic [127:0] i_Data,
  output logic [127:0] o_Data
);

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    SBox u_sbox (
      .i_fDec (i_fDec),
      .i_Byte (i_Data[8*g +: 8]),
      .o_Byte (o_Data[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes128_dec_core.sv
// Iterative AES-128 inverse cipher: one forward key expansion per key load, then one
// decrypt round per clock with round keys regenerated backwards from round key 10.
module aes128_dec_core
  import aes128_pkg::*;
(
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_KeyValid,
  input  logic [127:0] i_Key,
  output logic         o_KeyReady,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Data,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Data
);

  state_e               r_State;
  logic [BLOCK_W-1:0]   r_Rk10;
  logic [BLOCK_W-1:0]   r_WKey;
  logic [BLOCK_W-1:0]   r_Data;
  logic [3:0]           r_Round;
  logic [7:0]           r_Rcon;
  logic                 r_KeyReady;
  logic                 r_Valid;

  logic [31:0]          w_W0, w_W1, w_W2, w_W3;
  logic [31:0]          w_InvW1, w_InvW2, w_InvW3;
  logic [31:0]          w_SubIn, w_SubOut, w_T;
  logic [7:0]           w_RconFwd, w_RconSel;
  logic [BLOCK_W-1:0]   w_NextKey;
  logic [BLOCK_W-1:0]   w_Isb, w_Ark, w_Imc, w_RoundOut;

  // One key-schedule step: forward in KEYX, inverse in ROUND, sharing SubWord
  always_comb begin
    {w_W0, w_W1, w_W2, w_W3} = r_WKey;
    w_InvW3   = w_W3 ^ w_W2;
    w_InvW2   = w_W2 ^ w_W1;
    w_InvW1   = w_W1 ^ w_W0;
    w_SubIn   = (r_State == StRound) ? rot_word(w_InvW3) : rot_word(w_W3);
    w_RconFwd = (r_Round < 4'(NR)) ? RCON[r_Round] : 8'h00;
    w_RconSel = (r_State == StRound) ? r_Rcon : w_RconFwd;
    w_T       = w_SubOut ^ {w_RconSel, 24'h000000};
    if (r_State == StRound) begin
      w_NextKey = {w_W0 ^ w_T, w_InvW1, w_InvW2, w_InvW3};
    end else begin
      w_NextKey[127:96] = w_W0 ^ w_T;
      w_NextKey[95:64]  = w_W1 ^ w_NextKey[127:96];
      w_NextKey[63:32]  = w_W2 ^ w_NextKey[95:64];
      w_NextKey[31:0]   = w_W3 ^ w_NextKey[63:32];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_subword
    SBox u_sbox (
      .i_fDec (1'b0),
      .i_Byte (w_SubIn[8*g +: 8]),
      .o_Byte (w_SubOut[8*g +: 8])
    );
  end

  SubByte u_inv_sub (
    .i_fDec (1'b1),
    .i_Data (inv_shift_rows(r_Data)),
    .o_Data (w_Isb)
  );

  assign w_Ark = w_Isb ^ w_NextKey;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    InvMixColumn u_imc (
      .i_Col (w_Ark[32*c +: 32]),
      .o_Col (w_Imc[32*c +: 32])
    );
  end

  // Final round has no InvMixColumns
  assign w_RoundOut = (r_Round == 4'd0) ? w_Ark : w_Imc;

  // Control FSM and datapath registers; rk10 only changes on a completed key expansion
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State    <= StIdle;
      r_Rk10     <= '0;
      r_WKey     <= '0;
      r_Data     <= '0;
      r_Round    <= '0;
      r_Rcon     <= '0;
      r_KeyReady <= 1'b0;
      r_Valid    <= 1'b0;
    end else begin
      unique case (r_State)
        StIdle: begin
          if (i_KeyValid) begin
            r_WKey     <= i_Key;
            r_Round    <= '0;
            r_KeyReady <= 1'b0;
            r_State    <= StKeyx;
          end else if (i_Valid && r_KeyReady) begin
            r_Data  <= i_Data ^ r_Rk10;
            r_WKey  <= r_Rk10;
            r_Round <= 4'(NR - 1);
            r_Rcon  <= 8'h36;
            r_State <= StRound;
          end
        end
        StKeyx: begin
          r_WKey  <= w_NextKey;
          r_Round <= r_Round + 4'd1;
          if (r_Round == 4'(NR - 1)) begin
            r_Rk10     <= w_NextKey;
            r_KeyReady <= 1'b1;
            r_State    <= StIdle;
          end
        end
        StRound: begin
          r_WKey  <= w_NextKey;
          r_Data  <= w_RoundOut;
          // Walk the Rcon sequence backwards; 0x1B is preceded by 0x80
          r_Rcon  <= (r_Rcon == 8'h1B) ? 8'h80 : (r_Rcon >> 1);
          r_Round <= r_Round - 4'd1;
          if (r_Round == 4'd0) begin
            r_Valid <= 1'b1;
            r_State <= StDone;
          end
        end
        StDone: begin
          if (i_Ready) begin
            r_Valid <= 1'b0;
            r_State <= StIdle;
          end
        end
        default: r_State <= StIdle;
      endcase
    end
  end

  assign o_KeyReady = r_KeyReady;
  assign o_Valid    = r_Valid;
  assign o_Data     = r_Valid ? r_Data : '0;
  assign o_Ready    = (r_State == StIdle) && r_KeyReady && !i_KeyValid;

endmodule

// File: tb/tb_aes128_dec_core.sv
// Scoreboard bench for aes128_dec_core: blocks are produced by a reference AES encryptor
// and the expected plaintext is queued at issue time; a monitor pops on each handshake.
module tb_aes128_dec_core;

  logic         i_Clk = 1'b0;
  logic         i_Rst = 1'b1;
  logic         i_KeyValid = 1'b0;
  logic [127:0] i_Key = '0;
  logic         o_KeyReady;
  logic         i_Valid = 1'b0;
  logic         o_Ready;
  logic [127:0] i_Data = '0;
  logic         o_Valid;
  logic         i_Ready = 1'b0;
  logic [127:0] o_Data;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] exp_q[$];
  bit           rdy_rand = 1'b0;

  localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;

  aes128_dec_core dut (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_KeyValid (i_KeyValid),
    .i_Key      (i_Key),
    .o_KeyReady (o_KeyReady),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .i_Data     (i_Data),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Data     (o_Data)
  );

  always #5 i_Clk = ~i_Clk;

  // ---------------- reference model (forward AES-128) ----------------
  logic [7:0]  sbox_t [256];
  logic [31:0] ks_w [44];

  // Carry-less product then polynomial reduction by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] sub_word_m(input logic [31:0] x);
    return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
  endfunction

  function automatic void expand_key(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) ks_w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ks_w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word_m({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      ks_w[i] = ks_w[i-4] ^ t;
    end
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   st  [16];
    logic [7:0]   tmp [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    expand_key(key);
    for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8] ^ ks_w[k/4][31-8*(k%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) st[k] = sbox_t[st[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) tmp[4*c+r] = st[4*((c+r)%4)+r];
      for (int c = 0; c < 4; c++) begin
        a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
        if (rnd != 10) begin
          st[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          st[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          st[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          st[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end else begin
          st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
        end
      end
      for (int k = 0; k < 16; k++) st[k] = st[k] ^ ks_w[4*rnd + k/4][31-8*(k%4) -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  // Load a key and require o_KeyReady exactly 10 cycles after the accept edge
  task automatic load_key(input logic [127:0] key, input bit with_valid);
    int n;
    i_KeyValid = 1'b1;
    i_Key      = key;
    if (with_valid) begin
      i_Valid = 1'b1;
      i_Data  = C1_CT;
      #1;
      chk("precedence_ready_low", {127'd0, o_Ready}, 128'd0);
    end
    step();
    i_KeyValid = 1'b0;
    i_Valid    = 1'b0;
    i_Key      = rand128();
    n = 0;
    while (!o_KeyReady && n < 50) begin
      if (o_Ready) chk("keyx_ready_low", {127'd0, o_Ready}, 128'd0);
      step();
      n++;
    end
    chk("key_latency", 128'(n), 128'd10);
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] pt, input bit push);
    int n;
    repeat ($urandom_range(0, 2)) step();
    n = 0;
    while (!o_Ready && n < 100) begin
      step();
      n++;
    end
    if (!o_Ready) begin
      chk("accept_timeout", {127'd0, o_Ready}, 128'd1);
    end else begin
      i_Valid = 1'b1;
      i_Data  = ct;
      if (push) exp_q.push_back(pt);
      step();
      i_Valid = 1'b0;
      i_Data  = rand128();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
    end
  endtask

  // ---------------- monitor: pops on every o_Valid && i_Ready handshake ----------------
  initial begin
    forever begin
      @(negedge i_Clk);
      if (!i_Rst && o_Valid && i_Ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got %h with no block outstanding", o_Data);
        end else begin
          chk("plaintext", o_Data, exp_q.pop_front());
        end
      end
    end
  end

  // Random downstream backpressure during the random phase
  initial begin
    forever begin
      @(posedge i_Clk);
      #1;
      if (rdy_rand) i_Ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    repeat (90000) @(posedge i_Clk);
    $display("FAIL watchdog: got no finish, expected finish within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [127:0] key, pt, ct, rk;
    logic [7:0]   inv, s, aff_c;
    int           n;

    // Forward S-box from brute-force field inverse and the affine map
    aff_c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
      sbox_t[x] = s;
    end

    repeat (3) step();
    i_Rst = 1'b0;
    step();
    chk("reset_key_ready", {127'd0, o_KeyReady}, 128'd0);
    chk("reset_ready", {127'd0, o_Ready}, 128'd0);
    chk("reset_valid", {127'd0, o_Valid}, 128'd0);
    chk("reset_data", o_Data, 128'd0);

    // Block offered with no key loaded is never accepted
    i_Valid = 1'b1;
    i_Data  = C1_CT;
    repeat (15) begin
      step();
      chk("nokey_ready", {127'd0, o_Ready}, 128'd0);
      chk("nokey_valid", {127'd0, o_Valid}, 128'd0);
    end
    i_Valid = 1'b0;

    // FIPS C.1 with exact decrypt latency
    load_key(C1_KEY, 1'b0);
    chk("c1_rk10", dut.r_Rk10, C1_RK10);
    i_Ready = 1'b0;
    send_block(C1_CT, C1_PT, 1'b1);
    n = 0;
    while (!o_Valid && n < 50) begin
      step();
      n++;
    end
    chk("dec_latency", 128'(n), 128'd10);
    i_Ready = 1'b1;
    wait_drain();

    // FIPS B with 20 cycles of backpressure, then the same block again
    load_key(B_KEY, 1'b0);
    chk("b_rk10", dut.r_Rk10, B_RK10);
    i_Ready = 1'b0;
    send_block(B_CT, B_PT, 1'b1);
    n = 0;
    while (!o_Valid && n < 50) begin
      step();
      n++;
    end
    repeat (20) begin
      chk("bp_valid", {127'd0, o_Valid}, 128'd1);
      chk("bp_data", o_Data, B_PT);
      chk("bp_ready", {127'd0, o_Ready}, 128'd0);
      step();
    end
    i_Ready = 1'b1;
    step();
    chk("release_valid", {127'd0, o_Valid}, 128'd0);
    chk("release_ready", {127'd0, o_Ready}, 128'd1);
    send_block(B_CT, B_PT, 1'b1);
    wait_drain();

    // Key load and block together: key wins, no block decrypted
    load_key(C1_KEY, 1'b1);
    chk("precedence_rk10", dut.r_Rk10, C1_RK10);
    repeat (3) begin
      step();
      chk("precedence_no_valid", {127'd0, o_Valid}, 128'd0);
    end
    send_block(C1_CT, C1_PT, 1'b1);
    wait_drain();

    // Reset sampled at edge E5 of a decrypt
    send_block(C1_CT, C1_PT, 1'b0);
    repeat (4) step();
    i_Rst = 1'b1;
    step();
    chk("midrst_key_ready", {127'd0, o_KeyReady}, 128'd0);
    chk("midrst_valid", {127'd0, o_Valid}, 128'd0);
    chk("midrst_ready", {127'd0, o_Ready}, 128'd0);
    chk("midrst_data", o_Data, 128'd0);
    i_Rst   = 1'b0;
    i_Valid = 1'b1;
    i_Data  = C1_CT;
    repeat (3) begin
      step();
      chk("midrst_no_accept", {127'd0, o_Ready}, 128'd0);
      chk("midrst_no_valid", {127'd0, o_Valid}, 128'd0);
    end
    i_Valid = 1'b0;
    load_key(C1_KEY, 1'b0);
    send_block(C1_CT, C1_PT, 1'b1);
    wait_drain();

    // Random keys and plaintexts through the reference encryptor
    rdy_rand = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      key = rand128();
      pt  = rand128();
      ct  = aes_enc(key, pt);
      rk  = {ks_w[40], ks_w[41], ks_w[42], ks_w[43]};
      load_key(key, 1'b0);
      chk("rand_rk10", dut.r_Rk10, rk);
      send_block(ct, pt, 1'b1);
      wait_drain();
    end
    rdy_rand = 1'b0;
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
